// File: rtl/mesh_pkg.sv
// Shared mesh packet definitions: address field width, field offsets, packet struct and pack helper.
package mesh_pkg;

    localparam int ADDR_W   = 4;
    localparam int PKT_W    = 32;
    localparam int PAY_W    = PKT_W - 2*ADDR_W - 1;
    localparam int ROW_MSB  = PKT_W - 1;
    localparam int COL_MSB  = ROW_MSB - ADDR_W;
    localparam int MODE_BIT = COL_MSB - ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] row;
        logic [ADDR_W-1:0] col;
        logic              mode;
        logic [PAY_W-1:0]  payload;
    } packet_t;

    function automatic packet_t pack_pkt(input logic [ADDR_W-1:0] row,
                                         input logic [ADDR_W-1:0] col,
                                         input logic              mode,
                                         input logic [PAY_W-1:0]  payload);
        packet_t p;
        p.row     = row;
        p.col     = col;
        p.mode    = mode;
        p.payload = payload;
        return p;
    endfunction

endpackage

// File: rtl/mesh_sync_fifo.sv
// Synchronous FIFO with combinational head read; occupancy tracked by an explicit count register.
module mesh_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pop_fire;
    logic             push_fire;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CW'(DEPTH));
    assign count_o   = count_q;
    assign rdata_o   = empty_o ? '0 : mem_q[rd_ptr_q];
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
    assign pop_fire  = pop_i && !empty_o;
    assign push_fire = push_i && (!full_o || pop_fire);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_fire) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_fire)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_fire && !pop_fire)      count_d = count_q + 1'b1;
        else if (pop_fire && !push_fire) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/mesh_src_port.sv
// Terminal-side source adapter: packs requests, queues them and presents the head to the router.
// Optional destination range check enabled by defining MESH_SRC_DST_CHECK_EN.
module mesh_src_port #(
    parameter int ROWS    = 4,
    parameter int COLUMS  = 4,
    parameter int PCKG_SZ = 32,
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = mesh_pkg::ADDR_W,
    parameter int CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_row,
    input  logic [ADDR_W-1:0]            wr_col,
    input  logic                         wr_mode,
    input  logic [PCKG_SZ-2*ADDR_W-2:0]  wr_payload,
    output logic                         full_o,
    output logic [$clog2(DEPTH):0]       count_o,
    output logic                         pndng_o,
    output logic [PCKG_SZ-1:0]           data_o,
    input  logic                         pop_i,
    output logic [CNT_W-1:0]             drop_cnt_o,
    output logic                         pop_err_o,
    output logic [CNT_W-1:0]             bad_dst_cnt_o
);
    import mesh_pkg::*;

    logic [PCKG_SZ-1:0] wdata;
    logic               empty;
    logic               dst_legal;
    logic               dst_ok;
    logic               push_req;
    logic               full_drop;
    logic               drop_evt;
    logic [CNT_W-1:0]   drop_q, drop_d;
    logic               pop_err_q, pop_err_d;

    // Row field sits at the top, then column, then mode; payload fills the rest.
    assign wdata     = {wr_row, wr_col, wr_mode, wr_payload};
    assign dst_legal = (wr_row >= ADDR_W'(1)) && (wr_row <= ADDR_W'(ROWS)) &&
                       (wr_col >= ADDR_W'(1)) && (wr_col <= ADDR_W'(COLUMS));

`ifdef MESH_SRC_DST_CHECK_EN
    logic [CNT_W-1:0] bad_q, bad_d;
    logic             bad_evt;

    assign dst_ok  = dst_legal;
    assign bad_evt = wr_en && !dst_legal;
    assign bad_d   = (bad_evt && (bad_q != '1)) ? bad_q + 1'b1 : bad_q;

    always_ff @(posedge clk) begin
        if (reset) bad_q <= '0;
        else       bad_q <= bad_d;
    end
    assign bad_dst_cnt_o = bad_q;
`else
    logic unused_dst_legal;
    assign unused_dst_legal = dst_legal;
    assign dst_ok           = 1'b1;
    assign bad_dst_cnt_o    = '0;
`endif

    assign push_req  = wr_en && dst_ok;
    assign full_drop = push_req && full_o && !(pop_i && pndng_o);
    assign drop_evt  = (wr_en && !dst_ok) || full_drop;

    always_comb begin
        drop_d    = drop_q;
        pop_err_d = pop_err_q;
        if (drop_evt && (drop_q != '1)) drop_d = drop_q + 1'b1;
        if (pop_i && !pndng_o)          pop_err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_q    <= '0;
            pop_err_q <= 1'b0;
        end else begin
            drop_q    <= drop_d;
            pop_err_q <= pop_err_d;
        end
    end

    mesh_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PCKG_SZ)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_req),
        .pop_i   (pop_i),
        .wdata_i (wdata),
        .rdata_o (data_o),
        .full_o  (full_o),
        .empty_o (empty),
        .count_o (count_o)
    );

    assign pndng_o    = !empty;
    assign drop_cnt_o = drop_q;
    assign pop_err_o  = pop_err_q;

endmodule

// File: tb/tb_mesh_src_port.sv
// Directed bench for mesh_src_port: vector table plus hand-written full/empty/reset sequences.
module tb_mesh_src_port;
  import mesh_pkg::*;

  logic              clk;
  logic              reset;
  logic              wr_en;
  logic [3:0]        wr_row;
  logic [3:0]        wr_col;
  logic              wr_mode;
  logic [22:0]       wr_payload;
  logic              full_o;
  logic [3:0]        count_o;
  logic              pndng_o;
  logic [31:0]       data_o;
  logic              pop_i;
  logic [7:0]        drop_cnt_o;
  logic              pop_err_o;
  logic [7:0]        bad_dst_cnt_o;

  int checks;
  int failures;
  logic [31:0] exp_q[$];

  mesh_src_port dut (
    .clk           (clk),
    .reset         (reset),
    .wr_en         (wr_en),
    .wr_row        (wr_row),
    .wr_col        (wr_col),
    .wr_mode       (wr_mode),
    .wr_payload    (wr_payload),
    .full_o        (full_o),
    .count_o       (count_o),
    .pndng_o       (pndng_o),
    .data_o        (data_o),
    .pop_i         (pop_i),
    .drop_cnt_o    (drop_cnt_o),
    .pop_err_o     (pop_err_o),
    .bad_dst_cnt_o (bad_dst_cnt_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver: apply inputs, take one posedge, settle 1 time unit past it
  task automatic step(input logic en, input logic [3:0] row, input logic [3:0] col,
                      input logic mode, input logic [22:0] pay, input logic pop);
    wr_en = en; wr_row = row; wr_col = col; wr_mode = mode; wr_payload = pay; pop_i = pop;
    @(posedge clk);
    #1;
    wr_en = 1'b0; pop_i = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 4'd0, 4'd0, 1'b0, 23'd0, 1'b0);
    step(1'b0, 4'd0, 4'd0, 1'b0, 23'd0, 1'b0);
    reset = 1'b0;
  endtask

  typedef struct {
    logic        en;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        mode;
    logic [22:0] pay;
    logic        pop;
    logic        exp_pndng;
    logic [31:0] exp_data;
    logic [3:0]  exp_count;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0] a, b, c, w;
    checks = 0; failures = 0;
    reset = 1'b0; wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_mode = 1'b0;
    wr_payload = '0; pop_i = 1'b0;

    a = pack_pkt(4'd1, 4'd1, 1'b0, 23'h000001);
    b = pack_pkt(4'd4, 4'd4, 1'b1, 23'h7FFFFF);
    c = pack_pkt(4'd3, 4'd2, 1'b0, 23'h123456);
    //        en    row   col   mode  pay           pop   pndng data  cnt   err
    vecs[0] = '{1'b1, 4'd1, 4'd1, 1'b0, 23'h000001, 1'b0, 1'b1, a,    4'd1, 1'b0};
    vecs[1] = '{1'b1, 4'd4, 4'd4, 1'b1, 23'h7FFFFF, 1'b0, 1'b1, a,    4'd2, 1'b0};
    vecs[2] = '{1'b1, 4'd3, 4'd2, 1'b0, 23'h123456, 1'b1, 1'b1, b,    4'd2, 1'b0};
    vecs[3] = '{1'b0, 4'd0, 4'd0, 1'b0, 23'h000000, 1'b0, 1'b1, b,    4'd2, 1'b0};
    vecs[4] = '{1'b0, 4'd0, 4'd0, 1'b0, 23'h000000, 1'b1, 1'b1, c,    4'd1, 1'b0};
    vecs[5] = '{1'b0, 4'd0, 4'd0, 1'b0, 23'h000000, 1'b1, 1'b0, 32'h0, 4'd0, 1'b0};
    vecs[6] = '{1'b0, 4'd0, 4'd0, 1'b0, 23'h000000, 1'b1, 1'b0, 32'h0, 4'd0, 1'b1};
    vecs[7] = '{1'b1, 4'd1, 4'd1, 1'b0, 23'h000001, 1'b1, 1'b1, a,    4'd1, 1'b1};

    // reset state
    do_reset();
    chk("rst_pndng", 32'(pndng_o), 32'd0);
    chk("rst_data", data_o, 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_full", 32'(full_o), 32'd0);
    chk("rst_drop", 32'(drop_cnt_o), 32'd0);
    chk("rst_err", 32'(pop_err_o), 32'd0);
    chk("rst_bad", 32'(bad_dst_cnt_o), 32'd0);

    // first push: latency 1, then head stable
    step(1'b1, 4'd2, 4'd3, 1'b1, 23'h5A5, 1'b0);
    chk("first_pndng", 32'(pndng_o), 32'd1);
    chk("first_data", data_o, 32'h238005A5);
    chk("first_count", 32'(count_o), 32'd1);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 4'd0, 4'd0, 1'b0, 23'd0, 1'b0);
      chk("stable_data", data_o, 32'h238005A5);
    end
    step(1'b0, 4'd0, 4'd0, 1'b0, 23'd0, 1'b1);
    chk("first_pop_pndng", 32'(pndng_o), 32'd0);
    chk("first_pop_data", data_o, 32'd0);

    // vector table
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].en, vecs[i].row, vecs[i].col, vecs[i].mode, vecs[i].pay, vecs[i].pop);
      chk($sformatf("vec%0d_pndng", i), 32'(pndng_o), 32'(vecs[i].exp_pndng));
      chk($sformatf("vec%0d_data", i), data_o, vecs[i].exp_data);
      chk($sformatf("vec%0d_count", i), 32'(count_o), 32'(vecs[i].exp_count));
      chk($sformatf("vec%0d_err", i), 32'(pop_err_o), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_drop", i), 32'(drop_cnt_o), 32'd0);
    end
    reset = 1'b1;
    step(1'b0, 4'd0, 4'd0, 1'b0, 23'd0, 1'b0);
    reset = 1'b0;
    chk("err_cleared", 32'(pop_err_o), 32'd0);
    chk("err_rst_count", 32'(count_o), 32'd0);

    // fill, overflow drop, push+pop while full, drain in order
    for (int i = 0; i < 8; i++) begin
      w = pack_pkt(4'(1 + i % 4), 4'(4 - i % 4), 1'(i), 23'(32'h100 + i));
      exp_q.push_back(w);
      step(1'b1, 4'(1 + i % 4), 4'(4 - i % 4), 1'(i), 23'(32'h100 + i), 1'b0);
    end
    chk("fill_full", 32'(full_o), 32'd1);
    chk("fill_count", 32'(count_o), 32'd8);
    step(1'b1, 4'd2, 4'd2, 1'b0, 23'h0DEAD, 1'b0);
    chk("ovf_drop", 32'(drop_cnt_o), 32'd1);
    chk("ovf_count", 32'(count_o), 32'd8);
    chk("ovf_head", data_o, exp_q[0]);
    w = pack_pkt(4'd3, 4'd3, 1'b1, 23'h0BEEF);
    step(1'b1, 4'd3, 4'd3, 1'b1, 23'h0BEEF, 1'b1);
    void'(exp_q.pop_front());
    exp_q.push_back(w);
    chk("fullpp_count", 32'(count_o), 32'd8);
    chk("fullpp_drop", 32'(drop_cnt_o), 32'd1);
    chk("fullpp_full", 32'(full_o), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("drain_pndng", 32'(pndng_o), 32'd1);
      chk("drain_data", data_o, exp_q.pop_front());
      step(1'b0, 4'd0, 4'd0, 1'b0, 23'd0, 1'b1);
    end
    chk("drain_empty_pndng", 32'(pndng_o), 32'd0);
    chk("drain_empty_count", 32'(count_o), 32'd0);
    chk("drain_err", 32'(pop_err_o), 32'd0);

    // drop counter saturation
    for (int i = 0; i < 8; i++) step(1'b1, 4'd1, 4'd1, 1'b0, 23'(i), 1'b0);
    for (int i = 0; i < 300; i++) step(1'b1, 4'd1, 4'd1, 1'b0, 23'h7, 1'b0);
    chk("drop_sat", 32'(drop_cnt_o), 32'd255);
    chk("sat_count", 32'(count_o), 32'd8);

    // reset beats concurrent push and pop at count 5
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 4'd2, 4'd1, 1'b0, 23'(i), 1'b0);
    chk("pre_rst_count", 32'(count_o), 32'd5);
    reset = 1'b1;
    step(1'b1, 4'd1, 4'd1, 1'b0, 23'h55, 1'b1);
    reset = 1'b0;
    chk("rst_pp_count", 32'(count_o), 32'd0);
    chk("rst_pp_pndng", 32'(pndng_o), 32'd0);
    chk("rst_pp_data", data_o, 32'd0);
    chk("rst_pp_drop", 32'(drop_cnt_o), 32'd0);

    // destination check
    step(1'b1, 4'd0, 4'd2, 1'b0, 23'h1, 1'b0);
    step(1'b1, 4'd5, 4'd1, 1'b0, 23'h2, 1'b0);
`ifdef MESH_SRC_DST_CHECK_EN
    chk("bad_cnt", 32'(bad_dst_cnt_o), 32'd2);
    chk("bad_drop", 32'(drop_cnt_o), 32'd2);
    chk("bad_pndng", 32'(pndng_o), 32'd0);
    chk("bad_count", 32'(count_o), 32'd0);
`else
    chk("nochk_bad", 32'(bad_dst_cnt_o), 32'd0);
    chk("nochk_drop", 32'(drop_cnt_o), 32'd0);
    chk("nochk_count", 32'(count_o), 32'd2);
    chk("nochk_data", data_o, pack_pkt(4'd0, 4'd2, 1'b0, 23'h1));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
